// File: rtl/mem_io_responder_if.sv
// CPU byte-bus and console byte-stream signals of the memory/I-O responder.
// The master modport is the CPU/host side and the slave modport is the responder.
interface mem_io_responder_if;
   logic [31:0] cpu_a_i;
   logic        cpu_wr_i;
   logic [7:0]  cpu_dout_i;
   logic [7:0]  cpu_din_o;
   logic        cpu_rdy_o;
   logic        rx_valid_i;
   logic [7:0]  rx_data_i;
   logic        rx_ready_o;
   logic        tx_valid_o;
   logic [7:0]  tx_data_o;
   logic        tx_ready_i;
   logic        halt_o;
   logic        prog_end_o;

   modport master (
      output cpu_a_i, cpu_wr_i, cpu_dout_i, rx_valid_i, rx_data_i, tx_ready_i,
      input  cpu_din_o, cpu_rdy_o, rx_ready_o, tx_valid_o, tx_data_o, halt_o, prog_end_o
   );

   modport slave (
      input  cpu_a_i, cpu_wr_i, cpu_dout_i, rx_valid_i, rx_data_i, tx_ready_i,
      output cpu_din_o, cpu_rdy_o, rx_ready_o, tx_valid_o, tx_data_o, halt_o, prog_end_o
   );
endinterface

// File: rtl/mem_io_responder.sv
// Responder for the CPU byte bus: 128 KB byte RAM plus the I/O page at 0x30000
// (console RX/TX FIFOs, free-running cycle counter with snapshot, program stop).
module mem_io_responder #(
   parameter int RAM_AW  = 17,
   parameter int FIFO_AW = 3
) (
   input  logic              clk_in,
   input  logic              rst_in,
   mem_io_responder_if.slave bus
);
   localparam int               FIFO_DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] PTR_ONE    = {{FIFO_AW{1'b0}}, 1'b1};
   localparam int               RX         = 0;
   localparam int               TX         = 1;

   logic [17:0] addr;
   logic        wr;
   logic [7:0]  wdata;
   logic        unused_addr_hi;

   assign addr           = bus.cpu_a_i[17:0];
   assign wr             = bus.cpu_wr_i;
   assign wdata          = bus.cpu_dout_i;
   assign unused_addr_hi = ^bus.cpu_a_i[31:18];

   logic sel_ram;
   logic sel_io;
   logic io_data_port;
   logic io_ctrl_port;

   assign sel_ram      = ~addr[17];
   assign sel_io       = (addr[17:16] == 2'b11);
   assign io_data_port = sel_io && (addr[15:0] == 16'h0000);
   assign io_ctrl_port = sel_io && (addr[15:0] == 16'h0004);

   logic [1:0] fifo_push;
   logic [1:0] fifo_pop;
   logic [1:0] fifo_empty;
   logic [1:0] fifo_full;
   logic [7:0] fifo_wdata [0:1];
   logic [7:0] fifo_head  [0:1];

   // Index RX is the host-to-CPU stream, TX the CPU-to-host stream.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fifo
         logic [7:0]       mem [0:FIFO_DEPTH-1];
         logic [FIFO_AW:0] wr_ptr_reg;
         logic [FIFO_AW:0] rd_ptr_reg;

         assign fifo_empty[gi] = (wr_ptr_reg == rd_ptr_reg);
         assign fifo_full[gi]  = (wr_ptr_reg[FIFO_AW] != rd_ptr_reg[FIFO_AW]) &&
                                 (wr_ptr_reg[FIFO_AW-1:0] == rd_ptr_reg[FIFO_AW-1:0]);
         assign fifo_head[gi]  = mem[rd_ptr_reg[FIFO_AW-1:0]];

         always_ff @(posedge clk_in) begin
            if (rst_in) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
            end else begin
               if (fifo_push[gi]) begin
                  mem[wr_ptr_reg[FIFO_AW-1:0]] <= fifo_wdata[gi];
                  wr_ptr_reg                   <= wr_ptr_reg + PTR_ONE;
               end
               if (fifo_pop[gi]) begin
                  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
               end
            end
         end
      end
   endgenerate

   logic        halt_reg;
   logic        prog_end_reg;
   logic [31:0] cnt_reg;
   logic [31:0] snap_reg;
   logic        din_from_ram_reg;
   logic [7:0]  io_rd_reg;
   logic [7:0]  io_rd_next;
   logic [7:0]  ram_rd_reg;
   logic        stall;
   logic        accept;
   logic        rd_accept;
   logic        wr_accept;
   logic        ram_we;
   logic        ram_re;

   // The CPU holds its bus while frozen, so stall releases as soon as the FIFO condition clears.
   assign stall     = io_data_port &&
                      ((!wr && fifo_empty[RX]) || (wr && (wdata != 8'h00) && fifo_full[TX]));
   assign accept    = !rst_in && !halt_reg && !stall;
   assign rd_accept = accept && !wr;
   assign wr_accept = accept && wr;
   assign ram_we    = wr_accept && sel_ram;
   assign ram_re    = rd_accept && sel_ram;

   assign fifo_wdata[RX] = bus.rx_data_i;
   assign fifo_push[RX]  = bus.rx_valid_i && !fifo_full[RX];
   assign fifo_pop[RX]   = rd_accept && io_data_port;
   assign fifo_wdata[TX] = wdata;
   assign fifo_push[TX]  = wr_accept && io_data_port && (wdata != 8'h00);
   assign fifo_pop[TX]   = !fifo_empty[TX] && bus.tx_ready_i;

   logic [7:0] ram_mem [0:(1 << RAM_AW)-1];

   // Plain registered-read RAM; one access per cycle so no read/write collision exists.
   always_ff @(posedge clk_in) begin
      if (ram_we) begin
         ram_mem[addr[RAM_AW-1:0]] <= wdata;
      end
      if (ram_re) begin
         ram_rd_reg <= ram_mem[addr[RAM_AW-1:0]];
      end
   end

   always_comb begin
      io_rd_next = 8'h00;
      if (sel_io) begin
         case (addr[15:0])
            16'h0000: io_rd_next = fifo_head[RX];
            16'h0004: io_rd_next = cnt_reg[7:0];
            16'h0005: io_rd_next = snap_reg[15:8];
            16'h0006: io_rd_next = snap_reg[23:16];
            16'h0007: io_rd_next = snap_reg[31:24];
            default:  io_rd_next = 8'h00;
         endcase
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         halt_reg         <= 1'b0;
         prog_end_reg     <= 1'b0;
         cnt_reg          <= 32'd0;
         snap_reg         <= 32'd0;
         din_from_ram_reg <= 1'b0;
         io_rd_reg        <= 8'h00;
      end else begin
         cnt_reg      <= cnt_reg + 32'd1;
         prog_end_reg <= halt_reg && fifo_empty[TX];
         if (rd_accept) begin
            din_from_ram_reg <= sel_ram;
            io_rd_reg        <= io_rd_next;
            // Upper counter bytes come from the snapshot so a multi-byte read is coherent.
            if (io_ctrl_port) begin
               snap_reg <= cnt_reg;
            end
         end
         if (wr_accept && io_ctrl_port) begin
            halt_reg <= 1'b1;
         end
      end
   end

   assign bus.cpu_din_o  = din_from_ram_reg ? ram_rd_reg : io_rd_reg;
   assign bus.cpu_rdy_o  = accept;
   assign bus.rx_ready_o = !fifo_full[RX];
   assign bus.tx_valid_o = !fifo_empty[TX];
   assign bus.tx_data_o  = fifo_empty[TX] ? 8'h00 : fifo_head[TX];
   assign bus.halt_o     = halt_reg;
   assign bus.prog_end_o = prog_end_reg;
endmodule
